// File: rtl/keygen_pkg.sv
// Shared definitions for the public-key generator family: default key
// geometry, the null result value, the request mode encoding and the
// controller state type.
package keygen_pkg;

  // Default key width, modulus and additive offset.
  localparam int KEY_W = 8;
  localparam int KEY_P = 227;
  localparam int KEY_Q = 225;

  // Value driven on the key output whenever no legal key is presented.
  localparam int NULL_CHAR = 0;

  // The only legal request mode.
  localparam logic [1:0] MODE_GEN = 2'b01;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    HOLD   = 2'd2
  } keyState_e;

  // True when the request mode asks for key generation.
  function automatic logic modeIsGen(input logic [1:0] m);
    return (m == MODE_GEN);
  endfunction

endpackage

// File: rtl/mod_reduce_step.sv
// One step of modular reduction by conditional subtraction.
// done_o is high when the accumulator is already below the modulus.
module mod_reduce_step #(
  parameter int W = 8
) (
  input  logic [W:0] acc_i,
  input  logic [W:0] modulus_i,
  output logic [W:0] next_acc_o,
  output logic       done_o
);

  // Subtract the modulus once if the accumulator is not yet reduced.
  always_comb begin
    done_o     = (acc_i < modulus_i);
    next_acc_o = done_o ? acc_i : (acc_i - modulus_i);
  end

endmodule

// File: rtl/pub_key_gen_param.sv
// Parametrised public-key generator: public_key = (secret_key + Q) mod P.
// Requests arrive on a valid/ready handshake. Results are held on a
// valid/ready handshake until the consumer takes them.
// Optional build macro PKG_ERR_COUNT_EN adds a saturating count of
// rejected requests on err_count.
module pub_key_gen_param
  import keygen_pkg::*;
#(
  parameter int W = KEY_W,
  parameter int P = KEY_P,
  parameter int Q = KEY_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   mode,
  input  logic [W-1:0] secret_key,
  output logic         pk_valid,
  input  logic         pk_ready,
  output logic [W-1:0] public_key,
  output logic         pk_err
`ifdef PKG_ERR_COUNT_EN
  ,
  output logic [7:0]   err_count
`endif
);

  localparam longint MAX_VAL = (longint'(1) << W) - 1;

  // Modulus and offset widened to the accumulator width so the sum
  // Sk + Q can never overflow.
  localparam logic [W:0] P_EXT = (W+1)'(P);
  localparam logic [W:0] Q_EXT = (W+1)'(Q);

  // Reject parameter sets outside the supported range at elaboration.
  if ((P < 2) || (longint'(P) > MAX_VAL)) begin : gen_bad_p
    $error("pub_key_gen_param: P must satisfy 2 <= P <= 2^W-1");
  end
  if ((Q < 0) || (longint'(Q) > MAX_VAL)) begin : gen_bad_q
    $error("pub_key_gen_param: Q must satisfy 0 <= Q <= 2^W-1");
  end

  keyState_e    state_q, state_d;
  logic [W:0]   acc_q, acc_d;
  logic [W-1:0] pubKey_q, pubKey_d;
  logic         pkErr_q, pkErr_d;
  logic         pkValid_q, pkValid_d;

  logic         accept;
  logic         illegalReq;
  logic [W:0]   nextAcc;
  logic         reduceDone;

  // Only IDLE accepts requests, and never while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && (state_q == IDLE);

  // A zero key, a key not below the modulus or a non-generate mode is refused.
  assign illegalReq = (secret_key == '0)
                   || ({1'b0, secret_key} >= P_EXT)
                   || !modeIsGen(mode);

  mod_reduce_step #(
    .W (W)
  ) u_step (
    .acc_i      (acc_q),
    .modulus_i  (P_EXT),
    .next_acc_o (nextAcc),
    .done_o     (reduceDone)
  );

  // Next-state and result logic: load, reduce one step per cycle, then hold.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pubKey_d  = pubKey_q;
    pkErr_d   = pkErr_q;
    pkValid_d = pkValid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegalReq) begin
            pubKey_d  = W'(NULL_CHAR);
            pkErr_d   = 1'b1;
            pkValid_d = 1'b1;
            state_d   = HOLD;
          end else begin
            acc_d   = {1'b0, secret_key} + Q_EXT;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (!reduceDone) begin
          acc_d = nextAcc;
        end else begin
          pubKey_d  = acc_q[W-1:0];
          pkErr_d   = 1'b0;
          pkValid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (pkValid_q && pk_ready) begin
          pubKey_d  = W'(NULL_CHAR);
          pkErr_d   = 1'b0;
          pkValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and result registers; reset discards any work in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      pubKey_q  <= W'(NULL_CHAR);
      pkErr_q   <= 1'b0;
      pkValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pubKey_q  <= pubKey_d;
      pkErr_q   <= pkErr_d;
      pkValid_q <= pkValid_d;
    end
  end

  assign public_key = pubKey_q;
  assign pk_err     = pkErr_q;
  assign pk_valid   = pkValid_q;

`ifdef PKG_ERR_COUNT_EN
  logic [7:0] errCount_q;

  // Count accepted illegal requests, sticking at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount_q <= 8'd0;
    end else if (accept && illegalReq && (errCount_q != 8'hFF)) begin
      errCount_q <= errCount_q + 8'd1;
    end
  end

  assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_pub_key_gen_param.sv
// Self-checking bench for pub_key_gen_param. Two instances: default
// parameters (index 0) and W=10, P=11, Q=1000 (index 1). A timeline model
// predicts when each result appears and what it holds; it is compared with
// both instances on every falling clock edge.
module tb_pub_key_gen_param;

  logic clk;
  logic rstN;

  logic       reqValidD [2];
  logic [1:0] modeD     [2];
  logic [9:0] skD       [2];
  logic       pkReadyD  [2];

  logic       actReady [2];
  logic       actValid [2];
  logic       actErr   [2];
  logic [9:0] actKey   [2];
  logic [7:0] key0;
  logic [9:0] key1;
`ifdef PKG_ERR_COUNT_EN
  logic [7:0] actCnt [2];
`endif

  assign actKey[0] = {2'b00, key0};
  assign actKey[1] = key1;

  int     checks;
  int     errors;
  bit     checkEn;
  longint edgeNo;

  int     mP       [2];
  int     mQ       [2];
  bit     pending  [2];
  longint riseEdge [2];
  int     expKey   [2];
  bit     expErr   [2];
  int     expCnt   [2];

  pub_key_gen_param dut0 (
    .clk        (clk),
    .rst_n      (rstN),
    .req_valid  (reqValidD[0]),
    .req_ready  (actReady[0]),
    .mode       (modeD[0]),
    .secret_key (skD[0][7:0]),
    .pk_valid   (actValid[0]),
    .pk_ready   (pkReadyD[0]),
    .public_key (key0),
    .pk_err     (actErr[0])
`ifdef PKG_ERR_COUNT_EN
    ,
    .err_count  (actCnt[0])
`endif
  );

  pub_key_gen_param #(
    .W (10),
    .P (11),
    .Q (1000)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rstN),
    .req_valid  (reqValidD[1]),
    .req_ready  (actReady[1]),
    .mode       (modeD[1]),
    .secret_key (skD[1]),
    .pk_valid   (actValid[1]),
    .pk_ready   (pkReadyD[1]),
    .public_key (key1),
    .pk_err     (actErr[1])
`ifdef PKG_ERR_COUNT_EN
    ,
    .err_count  (actCnt[1])
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Plain arithmetic statement of the function: legality, result and step count.
  function automatic void modelResult(input int sk, input int mode, input int p, input int q,
                                      output bit err, output int key, output int k);
    err = (sk == 0) || (sk >= p) || (mode != 1);
    if (err) begin
      key = 0;
      k   = 0;
    end else begin
      key = (sk + q) % p;
      k   = (sk + q) / p;
    end
  endfunction

  // Timeline model: on each rising edge record accepts and retirements.
  initial begin
    bit e;
    int kv;
    int kk;
    int skv;
    edgeNo = 0;
    forever begin
      @(posedge clk);
      edgeNo++;
      if (rstN) begin
        for (int i = 0; i < 2; i++) begin
          if (pending[i]) begin
            if ((edgeNo > riseEdge[i]) && pkReadyD[i]) pending[i] = 1'b0;
          end else if (reqValidD[i]) begin
            skv = (i == 0) ? int'(skD[i][7:0]) : int'(skD[i]);
            modelResult(skv, int'(modeD[i]), mP[i], mQ[i], e, kv, kk);
            expErr[i]   = e;
            expKey[i]   = kv;
            riseEdge[i] = e ? edgeNo : edgeNo + longint'(kk) + 1;
            pending[i]  = 1'b1;
            if (e && (expCnt[i] < 255)) expCnt[i]++;
          end
        end
      end
    end
  end

  // Compare both instances with the model on every falling edge.
  initial begin
    bit ev;
    bit er;
    forever begin
      @(negedge clk);
      if (checkEn) begin
        for (int i = 0; i < 2; i++) begin
          ev = rstN && pending[i] && (edgeNo >= riseEdge[i]);
          er = rstN && !pending[i];
          checkOutput($sformatf("dut%0d_req_ready", i), longint'(actReady[i]), longint'(er));
          checkOutput($sformatf("dut%0d_pk_valid", i), longint'(actValid[i]), longint'(ev));
          checkOutput($sformatf("dut%0d_public_key", i), longint'(actKey[i]),
                      ev ? longint'(expKey[i]) : 0);
          checkOutput($sformatf("dut%0d_pk_err", i), longint'(actErr[i]),
                      ev ? longint'(expErr[i]) : 0);
`ifdef PKG_ERR_COUNT_EN
          checkOutput($sformatf("dut%0d_err_count", i), longint'(actCnt[i]), longint'(expCnt[i]));
`endif
        end
      end
    end
  end

  // One full transaction with pk_ready high, checked against literal values.
  task automatic applyStimulus(input int idx, input int sk, input int mode,
                               input int eKey, input int eErr, input int eLat);
    int lat;
    int n;
    @(negedge clk);
    skD[idx]       = 10'(sk);
    modeD[idx]     = 2'(mode);
    reqValidD[idx] = 1'b1;
    @(posedge clk);
    #1;
    reqValidD[idx] = 1'b0;
    skD[idx]       = (idx == 0) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(0, 1023));
    modeD[idx]     = 2'($urandom_range(0, 3));
    lat = 1;
    while ((actValid[idx] !== 1'b1) && (lat < 300)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("dut%0d_sk%0d_latency", idx, sk), longint'(lat), longint'(eLat));
    checkOutput($sformatf("dut%0d_sk%0d_key", idx, sk), longint'(actKey[idx]), longint'(eKey));
    checkOutput($sformatf("dut%0d_sk%0d_err", idx, sk), longint'(actErr[idx]), longint'(eErr));
    n = 0;
    while ((actValid[idx] === 1'b1) && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("dut%0d_sk%0d_retired", idx, sk), longint'(actValid[idx]), 0);
  endtask

  // Asserts reset away from the clock edge and clears the model.
  task automatic assertReset();
    @(negedge clk);
    #2;
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pending[i] = 1'b0;
      expCnt[i]  = 0;
    end
  endtask

  initial begin
    bit e;
    int kv;
    int kk;
    int lat;

    checks  = 0;
    errors  = 0;
    checkEn = 1'b0;
    mP[0] = 227; mQ[0] = 225;
    mP[1] = 11;  mQ[1] = 1000;
    for (int i = 0; i < 2; i++) begin
      pending[i]   = 1'b0;
      riseEdge[i]  = 0;
      expKey[i]    = 0;
      expErr[i]    = 1'b0;
      expCnt[i]    = 0;
      reqValidD[i] = 1'b0;
      modeD[i]     = 2'b01;
      skD[i]       = 10'd0;
      pkReadyD[i]  = 1'b1;
    end

    rstN = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    checkEn = 1'b1;

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_dut%0d_req_ready", i), longint'(actReady[i]), 0);
      checkOutput($sformatf("rst_dut%0d_pk_valid", i), longint'(actValid[i]), 0);
      checkOutput($sformatf("rst_dut%0d_public_key", i), longint'(actKey[i]), 0);
      checkOutput($sformatf("rst_dut%0d_pk_err", i), longint'(actErr[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rstN = 1'b1;
    #1;
    checkOutput("rel_dut0_req_ready", longint'(actReady[0]), 1);
    checkOutput("rel_dut1_req_ready", longint'(actReady[1]), 1);

    // Pin the model with hand-computed values.
    modelResult(5, 1, 227, 225, e, kv, kk);
    checkOutput("model_sk5_key", kv, 3);
    checkOutput("model_sk5_k", kk, 1);
    modelResult(226, 1, 227, 225, e, kv, kk);
    checkOutput("model_sk226_key", kv, 224);
    modelResult(2, 1, 227, 225, e, kv, kk);
    checkOutput("model_sk2_key", kv, 0);
    checkOutput("model_sk2_err", longint'(e), 0);
    modelResult(7, 1, 11, 1000, e, kv, kk);
    checkOutput("model_w10_key", kv, 6);
    checkOutput("model_w10_k", kk, 91);
    modelResult(10, 2, 227, 225, e, kv, kk);
    checkOutput("model_badmode_err", longint'(e), 1);

    // Legal requests, default parameters; latency counts the accepting edge.
    applyStimulus(0, 1,   1, 226, 0, 2);
    applyStimulus(0, 5,   1, 3,   0, 3);
    applyStimulus(0, 226, 1, 224, 0, 3);
    applyStimulus(0, 2,   1, 0,   0, 3);

    // Illegal requests.
    applyStimulus(0, 0,   1, 0, 1, 1);
    applyStimulus(0, 227, 1, 0, 1, 1);
    applyStimulus(0, 10,  2, 0, 1, 1);
`ifdef PKG_ERR_COUNT_EN
    checkOutput("err_count_after_3", longint'(actCnt[0]), 3);
`endif

    // Backpressure: result held for five cycles, then retired.
    pkReadyD[0] = 1'b0;
    @(negedge clk);
    skD[0]       = 10'd100;
    modeD[0]     = 2'b01;
    reqValidD[0] = 1'b1;
    @(posedge clk);
    #1;
    reqValidD[0] = 1'b0;
    modeD[0]     = 2'b11;
    skD[0]       = 10'd0;
    lat = 1;
    while ((actValid[0] !== 1'b1) && (lat < 50)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp_latency", longint'(lat), 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_valid", c), longint'(actValid[0]), 1);
      checkOutput($sformatf("bp_hold%0d_key", c), longint'(actKey[0]), 98);
      checkOutput($sformatf("bp_hold%0d_ready", c), longint'(actReady[0]), 0);
    end
    pkReadyD[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_retire_valid", longint'(actValid[0]), 0);
    checkOutput("bp_retire_key", longint'(actKey[0]), 0);
    checkOutput("bp_retire_ready", longint'(actReady[0]), 1);

    // Wide instance: many reduction steps.
    applyStimulus(1, 7, 1, 6, 0, 93);
    applyStimulus(1, 11, 1, 0, 1, 1);

`ifdef PKG_ERR_COUNT_EN
    // Drive the error counter into saturation.
    for (int r = 0; r < 260; r++) begin
      applyStimulus(0, 0, 1, 0, 1, 1);
    end
    checkOutput("err_count_saturated", longint'(actCnt[0]), 255);
`endif

    // Reset while both instances are reducing.
    @(negedge clk);
    skD[0] = 10'd226; modeD[0] = 2'b01; reqValidD[0] = 1'b1;
    skD[1] = 10'd7;   modeD[1] = 2'b01; reqValidD[1] = 1'b1;
    @(posedge clk);
    #1;
    reqValidD[0] = 1'b0;
    reqValidD[1] = 1'b0;
    assertReset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("midrst_dut%0d_valid", i), longint'(actValid[i]), 0);
      checkOutput($sformatf("midrst_dut%0d_key", i), longint'(actKey[i]), 0);
      checkOutput($sformatf("midrst_dut%0d_ready", i), longint'(actReady[i]), 0);
    end
    @(negedge clk);
    #2;
    rstN = 1'b1;
    applyStimulus(0, 1, 1, 226, 0, 2);
    applyStimulus(1, 7, 1, 6, 0, 93);

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pub_key_gen_param.md
Name: pub_key_gen_param

Overview:
Parametrised successor to the fixed 8-bit public-key generator. It computes Pk = (Sk + Q) mod P for a configurable width and modulus.
- Uses a valid/ready request and response handshake with backpressure.
- Reduces by iterative conditional subtraction, so Q may be any W-bit value.
- Sits between the key-entry front end and the cipher core, which consumes Pk.

Parameters:
W, 8, key width in bits.
P, 227, modulus; elaboration check 2 <= P <= 2^W-1.
Q, 225, additive offset; elaboration check 0 <= Q <= 2^W-1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous reset, active-low.
req_valid  in  1  request valid.
req_ready  out  1  block can accept a request.
mode  in  2  2'b01 = generate public key; every other code is illegal.
secret_key  in  W  Sk; sampled only on the accepting edge.
pk_valid  out  1  result valid.
pk_ready  in  1  downstream accepts the result.
public_key  out  W  result; all-zero (NULL_CHAR) when pk_err is high.
pk_err  out  1  request rejected (illegal Sk or illegal mode).

Behaviour:
- Reset values: req_ready=0 while rst_n is low, then 1 in IDLE. public_key=0, pk_valid=0, pk_err=0. Internal accumulator=0, state=IDLE.
- Accumulator acc is W+1 bits wide. Sum is zero-extended: acc = {0,Sk} + {0,Q}. No overflow is possible.
- Illegal request: Sk == 0, or Sk >= P, or mode != 2'b01.
- State IDLE:
  - req_ready=1.
  - Handshake completes on req_valid && req_ready.
  - Legal request: acc <= Sk+Q, next state REDUCE.
  - Illegal request: public_key<=0, pk_err<=1, pk_valid<=1, next state HOLD. Reduction is skipped.
- State REDUCE (one conditional subtraction per cycle):
  - If acc >= P: acc <= acc-P and stay in REDUCE.
  - Else: public_key <= acc[W-1:0], pk_err <= 0, pk_valid <= 1, next state HOLD.
- State HOLD:
  - public_key, pk_err and pk_valid are stable until pk_valid && pk_ready.
  - On that edge: pk_valid<=0, public_key<=0, pk_err<=0, next state IDLE.
  - req_ready=0, so no request is accepted in the same cycle as result retirement.
- Latency: k = floor((Sk+Q)/P) subtractions. pk_valid rises on the (k+2)-th edge after the accepting edge. The illegal path rises on the first edge after the accepting edge.
- Throughput: at most one request in flight. req_ready is low in REDUCE and HOLD.
- pk_ready held high in advance: the result retires on the first edge on which pk_valid=1 is sampled.
- Inputs mode and secret_key are ignored outside the accepting edge. Changes during REDUCE or HOLD have no effect.
- Asynchronous reset mid-operation: any in-flight result is discarded and all outputs return to their reset values immediately.
- Boundary with default parameters:
  - Sk=P-1=226 gives 451-227 = 224, k=1.
  - Sk=2 gives 227 >= P, so the result is 0 with k=1. This is a legal zero output and pk_err stays 0.

Optional Feature:
Macro PKG_ERR_COUNT_EN.
- Defined: adds output err_count [7:0].
  - Reset value 0.
  - Increments by 1 on every accepting edge of an illegal request.
  - Saturates at 255 and never wraps.
- Not defined: port and logic absent; the behaviour of all other ports is identical.

Decomposition:
Shared package keygen_pkg holds:
- Default localparams KEY_W=8, KEY_P=227, KEY_Q=225.
- NULL_CHAR constant.
- Mode encoding MODE_GEN=2'b01.
- State enum {IDLE, REDUCE, HOLD}.

One natural sub-module, mod_reduce_step: combinational. Input acc (W+1) and P. Outputs next_acc = (acc>=P) ? acc-P : acc, and done = (acc<P). Instantiated once by the FSM.

Test Plan:
- Default params, mode=01, Sk=1, pk_ready=1 -> public_key=226, pk_err=0, pk_valid 2 edges after accept (k=0).
- Sk=5 -> public_key=3 (k=1, 3 edges). Sk=226 -> 224. Sk=2 -> public_key=0, pk_err=0.
- Sk=0, Sk=227, and Sk=10 with mode=2'b10 -> pk_err=1, public_key=0, pk_valid 1 edge after accept. With PKG_ERR_COUNT_EN, err_count=3 afterwards.
- Backpressure: pk_ready=0 for 5 cycles after pk_valid -> outputs stable and req_ready=0 throughout. Raise pk_ready -> retire, then IDLE with req_ready=1 next cycle.
- W=10, P=11, Q=1000, Sk=7 -> acc=1007, k=91, public_key=6, pk_valid 93 edges after accept.
- Assert rst_n low during REDUCE -> pk_valid=0 and public_key=0 immediately. After release, a new request Sk=1 returns 226.
